// File: rtl/vga_pkg.sv
// Shared VGA widths, text-box geometry and the timing bundle type.
package vga_pkg;
  localparam int HCNT_W      = 11;
  localparam int RGB_W       = 12;
  localparam int CODE_W      = 7;
  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int TXT_COLS    = 16;
  localparam int TXT_ROWS    = 16;
  localparam int TXT_LATENCY = 5;
  localparam int BOX_W       = CHAR_W * TXT_COLS;
  localparam int BOX_H       = CHAR_H * TXT_ROWS;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
  } vga_bus_t;
endpackage

// File: rtl/signal_delay.sv
// Fixed-length shift register with synchronous active-low clear.
module signal_delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);
  logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= data;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign delayed = pipe[CLK_DEL-1];
endmodule

// File: rtl/draw_text_box.sv
// Overlays a 16x16 character text box on the pixel stream, addressing the
// external character and font ROMs and re-aligning timing by TXT_LATENCY.
module draw_text_box
  import vga_pkg::*;
#(
  parameter int               X_POS    = 448,
  parameter int               Y_POS    = 300,
  parameter logic [RGB_W-1:0] FG_COLOR = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HCNT_W-1:0] hcount_in,
  input  logic [HCNT_W-1:0] vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic              text_en,
  input  logic [CODE_W-1:0] char_code,
  input  logic [7:0]        char_pixels,
  output logic [7:0]        char_xy,
  output logic [10:0]       font_addr,
  output logic [HCNT_W-1:0] hcount_out,
  output logic [HCNT_W-1:0] vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);
  localparam logic signed [HCNT_W:0] XP    = (HCNT_W+1)'(X_POS);
  localparam logic signed [HCNT_W:0] YP    = (HCNT_W+1)'(Y_POS);
  localparam logic signed [HCNT_W:0] BW    = (HCNT_W+1)'(BOX_W);
  localparam logic signed [HCNT_W:0] BH    = (HCNT_W+1)'(BOX_H);
  localparam logic signed [HCNT_W:0] ZERO  = '0;

  logic signed [HCNT_W:0] relx, rely;
  logic                   en_frame, en_next, in_box;
  logic [2:0]             sub_x_d;
  logic                   in_box_d;
  logic [3:0]             line_d;
  logic                   fg;
  vga_bus_t               bus_in, bus_d;

  // One extra sign bit keeps pixels left of / above the box negative.
  assign relx = $signed({1'b0, hcount_in}) - XP;
  assign rely = $signed({1'b0, vcount_in}) - YP;

  // The value latched at frame start already governs pixel (0,0).
  assign en_next = (hcount_in == '0 && vcount_in == '0) ? text_en : en_frame;
  assign in_box  = en_next && (relx >= ZERO) && (relx < BW) &&
                   (rely >= ZERO) && (rely < BH);

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync: hsync_in, vsync: vsync_in,
                    hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

  signal_delay #(.WIDTH($bits(vga_bus_t)), .CLK_DEL(TXT_LATENCY)) u_bus_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (bus_in),
    .delayed (bus_d)
  );

  signal_delay #(.WIDTH(4), .CLK_DEL(TXT_LATENCY-1)) u_pix_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    ({relx[2:0], in_box}),
    .delayed ({sub_x_d, in_box_d})
  );

  signal_delay #(.WIDTH(4), .CLK_DEL(2)) u_line_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (rely[3:0]),
    .delayed (line_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_frame  <= 1'b0;
      char_xy   <= '0;
      font_addr <= '0;
      fg        <= 1'b0;
    end else begin
      en_frame  <= en_next;
      char_xy   <= {rely[7:4], relx[6:3]};
      font_addr <= {char_code, line_d};
      // Glyph bit 7 is the leftmost pixel of the cell.
      fg        <= in_box_d && char_pixels[3'd7 - sub_x_d];
    end
  end

  assign hcount_out = bus_d.hcount;
  assign vcount_out = bus_d.vcount;
  assign hsync_out  = bus_d.hsync;
  assign vsync_out  = bus_d.vsync;
  assign hblnk_out  = bus_d.hblnk;
  assign vblnk_out  = bus_d.vblnk;
  assign rgb_out    = (bus_d.hblnk || bus_d.vblnk) ? '0 :
                      fg ? FG_COLOR : bus_d.rgb;
endmodule
